sobel_window: RTL and testbench
===============================

SOBEL_WINDOW -- requirements
Module: sobel_window

Interface
REQ-001 Parameter ROW, default 125: pixels per image row; column counter modulus.
REQ-002 Parameter PIX_W, default 8: pixel width in bits.
REQ-003 Parameter THRESH, default 100: edge threshold on gradient magnitude.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 LOCKED  input  1  clock-good enable; low freezes all state.
REQ-007 sof  input  1  start-of-frame pulse; resynchronises column counter and window.
REQ-008 pixel_valid  input  1  pixel_in/step_in carry a memory read result this cycle.
REQ-009 step_in  input  2  vertical tap of pixel_in: 0 top, 1 middle, 2 bottom.
REQ-010 pixel_in  input  PIX_W  pixel read from image memory.
REQ-011 edge_valid  output  1  one-cycle strobe; edge_out/col_out valid.
REQ-012 edge_out  output  PIX_W  all-ones if edge, else zero.
REQ-013 col_out  output  15  linear column index of the window centre column.

Function
REQ-014 Accepted sample: LOCKED=1 and pixel_valid=1; nothing else changes state except sof.
REQ-015 Column assembly: step 0 loads top, 1 middle, 2 bottom; accepting step 2 with top and middle held commits the column.
REQ-016 Out-of-order: step 0 while a column is partial restarts that column; step 1 or 2 without preceding taps is discarded; step 3 ignored.
REQ-017 Commit shifts 3-column window: col0<=col1, col1<=col2, col2<=new; col0 oldest.
REQ-018 Column counter (15 bits, linear) increments per commit; in-row position wraps ROW-1 -> 0.
REQ-019 Windows whose three columns span a row boundary (in-row position 0 or 1 after commit) produce no edge_valid.
REQ-020 Gx = (p0,2 + 2*p1,2 + p2,2) - (p0,0 + 2*p1,0 + p2,0), Gy = bottom row weighted sum minus top row weighted sum; 11-bit signed, no overflow.
REQ-021 Magnitude = |Gx| + |Gy|, 11-bit unsigned (max 2040); edge iff magnitude > THRESH.
REQ-022 Pipeline: gradients registered on edge after commit; magnitude/compare registered next edge; edge_valid high exactly 2 clocks after the committing edge, for 1 cycle.
REQ-023 col_out = committing column index minus 1 (centre column), modulo 2^15.
REQ-024 LOCKED low: pipeline stages, counters and window hold; no edge_valid issued; resumes unchanged when LOCKED returns high.
REQ-025 sof accepted (with LOCKED=1): column counter, partial column and window-fill count cleared; in-flight pipeline results still emerge; sof with pixel_valid same cycle treats that sample as first of the new frame.
REQ-026 Throughput: one commit per 3 accepted samples; back-to-back commits every 3 cycles sustained.

Reset
REQ-027 reset low asynchronously clears window, partial column, counters, pipeline registers; edge_valid=0, edge_out=0, col_out=0.
REQ-028 Reset release synchronous to clk; first accepted sample after release treated as step-0 start of frame.

Configuration
REQ-029 Macro SOBEL_MAG_OUT_EN: when defined, adds output mag_out (11 bits) carrying the registered magnitude, valid with edge_valid, reset 0.
REQ-030 Without SOBEL_MAG_OUT_EN: no mag_out port; magnitude register internal only; edge behaviour identical.

Structure
REQ-031 Shared package holds PIX_W, ROW default, gradient width (11), step encodings (TOP/MID/BOT).
REQ-032 One sub-module sobel_gradient: combinational 3x3 -> Gx, Gy; registers remain in sobel_window.

Verification
REQ-033 Uniform 50 image, ROW=125: every window -> edge_valid with edge_out=0, no strobe at in-row positions 0,1.
REQ-034 Vertical step edge (cols <10 =0, >=10 =255) -> edge_out=255 at col_out 9 and 10 (|Gx|=1020), zero elsewhere.
REQ-035 Single column commit at cycle N -> edge_valid at N+2 exactly; LOCKED low 5 cycles mid-pipeline delays strobe by 5, same data.
REQ-036 Taps 0,1,0,1,2 -> first partial column discarded, one commit only.
REQ-037 reset low mid-frame -> outputs 0 immediately; after release sof-free restart produces first strobe only after 3 committed columns.
REQ-038 With SOBEL_MAG_OUT_EN, window top row 0, bottom row 255 -> mag_out=1020, edge_out=255.

Source files
------------

// File: rtl/sobel_window_pkg.sv
// Shared constants and types for the sobel_window edge detector.
package sobel_window_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int ROW_DEF   = 125;
  localparam int GRAD_W    = 11;
  localparam int COL_W     = 15;

  typedef enum logic [1:0] {
    STEP_TOP  = 2'd0,
    STEP_MID  = 2'd1,
    STEP_BOT  = 2'd2,
    STEP_NONE = 2'd3
  } step_e;

  // Absolute value of a gradient; |-1020| still fits the unsigned range.
  function automatic logic [GRAD_W-1:0] abs_grad(input logic signed [GRAD_W-1:0] g);
    return g[GRAD_W-1] ? GRAD_W'(-g) : GRAD_W'(g);
  endfunction

endpackage

// File: rtl/sobel_window_gradient.sv
// Combinational Sobel kernels over a 3x3 window; win[row][col], col 0 oldest.
module sobel_gradient
  import sobel_window_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic [2:0][2:0][PIX_W-1:0] win,
  output logic signed [GRAD_W-1:0]   gx,
  output logic signed [GRAD_W-1:0]   gy
);

  logic signed [GRAD_W-1:0] p [3][3];

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        p[r][c] = signed'(GRAD_W'(win[r][c]));
      end
    end
    gx = (p[0][2] + (p[1][2] <<< 1) + p[2][2]) - (p[0][0] + (p[1][0] <<< 1) + p[2][0]);
    gy = (p[2][0] + (p[2][1] <<< 1) + p[2][2]) - (p[0][0] + (p[0][1] <<< 1) + p[0][2]);
  end

endmodule

// File: rtl/sobel_window.sv
// Column-assembling 3x3 Sobel edge detector with a two-stage gradient/threshold pipeline.
// Optional macro SOBEL_MAG_OUT_EN exposes the registered magnitude on mag_out.
module sobel_window
  import sobel_window_pkg::*;
#(
  parameter int ROW    = ROW_DEF,
  parameter int PIX_W  = PIX_W_DEF,
  parameter int THRESH = 100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              LOCKED,
  input  logic              sof,
  input  logic              pixel_valid,
  input  logic [1:0]        step_in,
  input  logic [PIX_W-1:0]  pixel_in,
  output logic              edge_valid,
  output logic [PIX_W-1:0]  edge_out,
  output logic [COL_W-1:0]  col_out
`ifdef SOBEL_MAG_OUT_EN
  ,
  output logic [GRAD_W-1:0] mag_out
`endif
);

  localparam int POS_W = (ROW > 1) ? $clog2(ROW) : 1;
  localparam logic [POS_W-1:0]  POS_LAST = POS_W'(ROW - 1);
  localparam logic [GRAD_W-1:0] THR      = GRAD_W'(THRESH);

  logic [2:0][2:0][PIX_W-1:0] win_q;
  logic [PIX_W-1:0]           top_q, mid_q;
  logic                       have_top_q, have_mid_q;
  logic [COL_W-1:0]           col_cnt_q, win_col_q, g_col_q;
  logic [POS_W-1:0]           pos_q;
  logic [1:0]                 fill_q;
  logic                       win_new_q, g_valid_q;
  logic signed [GRAD_W-1:0]   gx, gy, gx_q, gy_q;
  logic [GRAD_W-1:0]          mag;
  step_e                      step;

  // A start-of-frame makes the same-cycle sample the first of the new frame,
  // so the frame state is viewed as already cleared before the sample acts.
  logic             sof_acc;
  logic             b_top, b_mid;
  logic [COL_W-1:0] b_col;
  logic [POS_W-1:0] b_pos;
  logic [1:0]       b_fill;

  assign sof_acc = LOCKED & sof;
  assign b_top   = sof_acc ? 1'b0 : have_top_q;
  assign b_mid   = sof_acc ? 1'b0 : have_mid_q;
  assign b_col   = sof_acc ? '0 : col_cnt_q;
  assign b_pos   = sof_acc ? '0 : pos_q;
  assign b_fill  = sof_acc ? '0 : fill_q;
  assign step    = step_e'(step_in);
  assign mag     = abs_grad(gx_q) + abs_grad(gy_q);

  sobel_gradient #(.PIX_W(PIX_W)) u_gradient (
    .win (win_q),
    .gx  (gx),
    .gy  (gy)
  );

`ifdef SOBEL_MAG_OUT_EN
  logic [GRAD_W-1:0] mag_q;
  assign mag_out = mag_q;
`endif

  // NOTE: the window is a small register array, not a RAM, so it takes the async reset like any other state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_q      <= '0;
      top_q      <= '0;
      mid_q      <= '0;
      have_top_q <= 1'b0;
      have_mid_q <= 1'b0;
      col_cnt_q  <= '0;
      pos_q      <= '0;
      fill_q     <= '0;
      win_new_q  <= 1'b0;
      win_col_q  <= '0;
      g_valid_q  <= 1'b0;
      gx_q       <= '0;
      gy_q       <= '0;
      g_col_q    <= '0;
      edge_valid <= 1'b0;
      edge_out   <= '0;
      col_out    <= '0;
`ifdef SOBEL_MAG_OUT_EN
      mag_q      <= '0;
`endif
    end else if (LOCKED) begin
      have_top_q <= b_top;
      have_mid_q <= b_mid;
      col_cnt_q  <= b_col;
      pos_q      <= b_pos;
      fill_q     <= b_fill;
      win_new_q  <= 1'b0;
      if (pixel_valid) begin
        case (step)
          STEP_TOP: begin
            top_q      <= pixel_in;
            have_top_q <= 1'b1;
            have_mid_q <= 1'b0;
          end
          STEP_MID: if (b_top) begin
            mid_q      <= pixel_in;
            have_mid_q <= 1'b1;
          end
          STEP_BOT: if (b_top && b_mid) begin
            for (int r = 0; r < 3; r++) begin
              win_q[r][0] <= win_q[r][1];
              win_q[r][1] <= win_q[r][2];
            end
            win_q[0][2] <= top_q;
            win_q[1][2] <= mid_q;
            win_q[2][2] <= pixel_in;
            have_top_q  <= 1'b0;
            have_mid_q  <= 1'b0;
            col_cnt_q   <= b_col + COL_W'(1);
            pos_q       <= (b_pos == POS_LAST) ? '0 : b_pos + POS_W'(1);
            fill_q      <= (b_fill == 2'd3) ? b_fill : b_fill + 2'd1;
            // Only windows of three columns from the same row are reported.
            win_new_q   <= (b_fill >= 2'd2) && (b_pos >= POS_W'(2));
            win_col_q   <= b_col - COL_W'(1);
          end
          default: ;
        endcase
      end
      g_valid_q <= win_new_q;
      if (win_new_q) begin
        gx_q    <= gx;
        gy_q    <= gy;
        g_col_q <= win_col_q;
      end
      edge_valid <= g_valid_q;
      if (g_valid_q) begin
        edge_out <= (mag > THR) ? '1 : '0;
        col_out  <= g_col_q;
`ifdef SOBEL_MAG_OUT_EN
        mag_q    <= mag;
`endif
      end
    end else begin
      // The strobe already shown this cycle must not repeat while frozen.
      edge_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sobel_window.sv
// Directed self-checking bench for sobel_window (ROW=125, PIX_W=8, THRESH=100).
module tb_sobel_window;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        locked = 1'b1;
  logic        sof = 1'b0;
  logic        pixel_valid = 1'b0;
  logic [1:0]  step_in = 2'd0;
  logic [7:0]  pixel_in = 8'd0;
  logic        edge_valid;
  logic [7:0]  edge_out;
  logic [14:0] col_out;
`ifdef SOBEL_MAG_OUT_EN
  logic [10:0] mag_out;
`endif

  sobel_window #(.ROW(125), .PIX_W(8), .THRESH(100)) dut (
    .clk         (clk),
    .reset       (reset),
    .LOCKED      (locked),
    .sof         (sof),
    .pixel_valid (pixel_valid),
    .step_in     (step_in),
    .pixel_in    (pixel_in),
    .edge_valid  (edge_valid),
    .edge_out    (edge_out),
    .col_out     (col_out)
`ifdef SOBEL_MAG_OUT_EN
    ,
    .mag_out     (mag_out)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cy;
    int col;
    int edg;
    int mag;
  } ev_t;

  ev_t obs[$];
  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;
  int  last_commit = 0;

  always @(negedge clk) begin
    if (edge_valid) begin
`ifdef SOBEL_MAG_OUT_EN
      obs.push_back('{cyc, int'(col_out), int'(edge_out), int'(mag_out)});
`else
      obs.push_back('{cyc, int'(col_out), int'(edge_out), 0});
`endif
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input logic s, input logic v, input logic [1:0] st, input logic [7:0] px);
    sof = s; pixel_valid = v; step_in = st; pixel_in = px;
    @(posedge clk);
    #1;
    sof = 1'b0; pixel_valid = 1'b0;
  endtask

  task automatic send_col(input logic [7:0] t, input logic [7:0] m, input logic [7:0] b,
                          input logic s);
    tick(s, 1'b1, 2'd0, t);
    tick(1'b0, 1'b1, 2'd1, m);
    tick(1'b0, 1'b1, 2'd2, b);
    last_commit = cyc;
  endtask

  task automatic expect_ev(input int col, input int cy, input int edg, input int mag);
    exp_q.push_back('{cy, col, edg, mag});
  endtask

  task automatic compare_events(input string tag);
    repeat (4) tick(1'b0, 1'b0, 2'd0, 8'd0);
    check({tag, "_count"}, obs.size(), exp_q.size());
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s[%0d].cycle", tag, i), obs[i].cy, exp_q[i].cy);
      check($sformatf("%s[%0d].col", tag, i), obs[i].col, exp_q[i].col);
      check($sformatf("%s[%0d].edge", tag, i), obs[i].edg, exp_q[i].edg);
`ifdef SOBEL_MAG_OUT_EN
      check($sformatf("%s[%0d].mag", tag, i), obs[i].mag, exp_q[i].mag);
`endif
    end
    obs.delete();
    exp_q.delete();
  endtask

  initial begin
    int n;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_edge_valid", edge_valid, 0);
    check("rst_edge_out", edge_out, 0);
    check("rst_col_out", col_out, 0);
`ifdef SOBEL_MAG_OUT_EN
    check("rst_mag_out", mag_out, 0);
`endif
    reset = 1'b1;
    tick(1'b0, 1'b0, 2'd0, 8'd0);

    // Uniform 50 over two rows: no strobe at in-row positions 0 and 1
    for (int c = 0; c < 250; c++) begin
      send_col(8'd50, 8'd50, 8'd50, c == 0);
      if ((c % 125) >= 2) expect_ev(c - 1, last_commit + 2, 0, 0);
    end
    compare_events("uniform");

    // Vertical step edge at column 10
    for (int c = 0; c < 20; c++) begin
      logic [7:0] v;
      v = (c < 10) ? 8'd0 : 8'd255;
      send_col(v, v, v, c == 0);
      if (c >= 2) begin
        if (c - 1 == 9 || c - 1 == 10) expect_ev(c - 1, last_commit + 2, 255, 1020);
        else expect_ev(c - 1, last_commit + 2, 0, 0);
      end
    end
    compare_events("vstep");

    // Horizontal edge: top row 0, bottom row 255
    for (int c = 0; c < 3; c++) send_col(8'd0, 8'd128, 8'd255, c == 0);
    expect_ev(1, last_commit + 2, 255, 1020);
    compare_events("hedge");

    // LOCKED low for 5 cycles mid-pipeline delays the strobe by 5
    for (int c = 0; c < 3; c++) send_col(8'd0, 8'd128, 8'd255, c == 0);
    n = last_commit;
    tick(1'b0, 1'b0, 2'd0, 8'd0);
    locked = 1'b0;
    repeat (5) tick(1'b0, 1'b0, 2'd0, 8'd0);
    locked = 1'b1;
    expect_ev(1, n + 7, 255, 1020);
    send_col(8'd0, 8'd128, 8'd255, 1'b0);
    expect_ev(2, last_commit + 2, 255, 1020);
    compare_events("locked");

    // Out-of-order taps: 0,1,0,1,2 commits once; stray taps are discarded
    send_col(8'd0, 8'd128, 8'd255, 1'b1);
    send_col(8'd0, 8'd128, 8'd255, 1'b0);
    tick(1'b0, 1'b1, 2'd0, 8'd200);
    tick(1'b0, 1'b1, 2'd1, 8'd200);
    tick(1'b0, 1'b1, 2'd0, 8'd0);
    tick(1'b0, 1'b1, 2'd1, 8'd128);
    tick(1'b0, 1'b1, 2'd2, 8'd255);
    expect_ev(1, cyc + 2, 255, 1020);
    tick(1'b0, 1'b1, 2'd2, 8'd9);
    tick(1'b0, 1'b1, 2'd1, 8'd9);
    tick(1'b0, 1'b1, 2'd3, 8'd9);
    tick(1'b0, 1'b1, 2'd2, 8'd9);
    send_col(8'd0, 8'd128, 8'd255, 1'b0);
    expect_ev(2, last_commit + 2, 255, 1020);
    compare_events("order");

    // Reset mid-frame while a strobe is showing
    for (int c = 0; c < 4; c++) begin
      send_col(8'd0, 8'd128, 8'd255, c == 0);
      if (c == 2) expect_ev(1, last_commit + 2, 255, 1020);
    end
    tick(1'b0, 1'b0, 2'd0, 8'd0);
    tick(1'b0, 1'b0, 2'd0, 8'd0);
    check("pre_reset_strobe", edge_valid, 1);
    reset = 1'b0;
    #1;
    check("async_edge_valid", edge_valid, 0);
    check("async_edge_out", edge_out, 0);
    check("async_col_out", col_out, 0);
`ifdef SOBEL_MAG_OUT_EN
    check("async_mag_out", mag_out, 0);
`endif
    compare_events("pre_reset");
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      send_col(8'd0, 8'd128, 8'd255, 1'b0);
      if (c >= 2) expect_ev(c - 1, last_commit + 2, 255, 1020);
    end
    compare_events("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
